// File: rtl/grf_pkg.sv
// Shared constants and types for the multi-port register file.
// Comb reads, registered writes; no flow control (always ready).
package grf_pkg;
   localparam int unsigned GRF_DATA_W = 32;
   localparam int unsigned GRF_ADDR_W = 5;
   localparam int unsigned ZERO_REG   = 0;

   typedef logic [GRF_ADDR_W-1:0] reg_addr_t;

   localparam string TRACE_FMT = "%0t@%08h: $%0d <= %08h";
endpackage

// File: rtl/grf_mp_if.sv
// Read/write/scoreboard bundle between the pipeline (master) and the register file (slave).
// Pure wiring: no latency, no backpressure.
interface grf_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rbusy;
   logic                     we0;
   logic [ADDR_W-1:0]        waddr0;
   logic [DATA_W-1:0]        wdata0;
   logic                     we1;
   logic [ADDR_W-1:0]        waddr1;
   logic [DATA_W-1:0]        wdata1;
   logic                     set_en;
   logic [ADDR_W-1:0]        set_addr;
   logic [31:0]              pc_w0;
   logic [31:0]              pc_w1;
   logic                     busy_any;

   modport master (
      output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, set_en, set_addr, pc_w0, pc_w1,
      input  rdata, rbusy, busy_any
   );
   modport slave (
      input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, set_en, set_addr, pc_w0, pc_w1,
      output rdata, rbusy, busy_any
   );
endinterface

// File: rtl/grf_scoreboard.sv
// Per-register busy bits: set on producer issue, cleared on writeback, set beats clear.
// Lookup is combinational; state updates at posedge; never stalls.
module grf_scoreboard
   import grf_pkg::*;
#(
   parameter int ADDR_W = GRF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr0_en,
   input  logic [ADDR_W-1:0]        clr0_addr,
   input  logic                     clr1_en,
   input  logic [ADDR_W-1:0]        clr1_addr,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD-1:0]        rbusy,
   output logic                     busy_any
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             c0;
   logic             c1;
   logic             s;

   assign c0 = clr0_en && (clr0_addr != ADDR_W'(ZERO_REG));
   assign c1 = clr1_en && (clr1_addr != ADDR_W'(ZERO_REG));
   assign s  = set_en  && (set_addr  != ADDR_W'(ZERO_REG));

   // Set is applied last so a new producer supersedes the completing one.
   always_comb begin
      busy_nxt = busy;
      if (c0) busy_nxt[clr0_addr] = 1'b0;
      if (c1) busy_nxt[clr1_addr] = 1'b0;
      if (s)  busy_nxt[set_addr]  = 1'b1;
      busy_nxt[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rbusy
      logic [ADDR_W-1:0] ra;
      logic              clr_hit;
      logic              set_hit;
      assign ra      = raddr[k*ADDR_W +: ADDR_W];
      assign clr_hit = (c0 && clr0_addr == ra) || (c1 && clr1_addr == ra);
      assign set_hit = s && (set_addr == ra);
      assign rbusy[k] = busy[ra] & ~((BYPASS != 0) & clr_hit & ~set_hit);
   end

   assign busy_any = |busy;
endmodule

// File: rtl/grf_mp.sv
// Multi-port GRF: NUM_RD comb reads, two writes (W1 wins), optional bypass, busy scoreboard.
// Read latency 0, write latency 1 cycle; never backpressures. Trace under GRF_TRACE_EN.
module grf_mp
   import grf_pkg::*;
#(
   parameter int DATA_W = GRF_DATA_W,
   parameter int ADDR_W = GRF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input logic      clk,
   input logic      reset,
   grf_mp_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              w0;
   logic              w1;

   assign w0 = bus.we0 && (bus.waddr0 != ADDR_W'(ZERO_REG));
   assign w1 = bus.we1 && (bus.waddr1 != ADDR_W'(ZERO_REG));

   // W1 assigned after W0 so it wins on an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (w0) regs[bus.waddr0] <= bus.wdata0;
         if (w1) regs[bus.waddr1] <= bus.wdata1;
      end
   end

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w0 && !(w1 && bus.waddr1 == bus.waddr0))
            $display("%s", $sformatf(TRACE_FMT, $time, bus.pc_w0, bus.waddr0, bus.wdata0));
         if (w1)
            $display("%s", $sformatf(TRACE_FMT, $time, bus.pc_w1, bus.waddr1, bus.wdata1));
      end
   end
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      assign ra = bus.raddr[k*ADDR_W +: ADDR_W];
      always_comb begin
         rd = regs[ra];
         if (ra == ADDR_W'(ZERO_REG))                      rd = '0;
         else if ((BYPASS != 0) && w1 && bus.waddr1 == ra) rd = bus.wdata1;
         else if ((BYPASS != 0) && w0 && bus.waddr0 == ra) rd = bus.wdata0;
      end
      assign bus.rdata[k*DATA_W +: DATA_W] = rd;
   end

   grf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .clr0_en   (bus.we0),
      .clr0_addr (bus.waddr0),
      .clr1_en   (bus.we1),
      .clr1_addr (bus.waddr1),
      .set_en    (bus.set_en),
      .set_addr  (bus.set_addr),
      .raddr     (bus.raddr),
      .rbusy     (bus.rbusy),
      .busy_any  (bus.busy_any)
   );
endmodule
